sprite_renderer: RTL and testbench
==================================

Name: sprite_renderer

Overview:
- Consumes the 16x16 RGBA sprite ROM and composites one sprite over the background RGB stream of the 640x480 VGA pipeline.
- During horizontal blanking it drives the ROM line index and captures the 64-bit row, 4 bits per pixel ordered R,G,B,A, with pixel 0 in bits[63:60].
- During active video it emits the composited 3-bit pixel, one cycle after its x/y.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- V_TOTAL, 525, total lines per frame, used for next-line wrap
- FETCH_X, 640, x value at which the row fetch starts; must be ≥ H_ACTIVE and ≤ H_TOTAL-3

Ports:
- clk  in  1  pixel clock
- reset_n  in  1  asynchronous, active-low reset
- frame_start  in  1  one-cycle pulse at start of vertical blank; latches sprite position
- x  in  10  current pixel column
- y  in  10  current line
- de  in  1  active-video enable for x/y
- spr_en  in  1  sprite enable, latched with position
- spr_x  in  10  sprite left column, live
- spr_y  in  10  sprite top line, live
- bg_rgb  in  3  background pixel for x/y
- line  out  4  row index to sprite ROM
- bits  in  64  ROM row data, combinational from line
- rgb_out  out  3  composited pixel
- de_out  out  1  de delayed 1 cycle
- hit  out  1  opaque sprite pixel on rgb_out this cycle

Behaviour:
- Reset, asynchronous: line=0, rgb_out=0, de_out=0, hit=0, line_buf=0, latched pos/enable=0, FSM=IDLE, pixel counter=0.
- Position latch: on frame_start, px<=spr_x, py<=spr_y, pen<=spr_en. Changes mid-frame take effect next frame only.
- Next line: ny = (y==V_TOTAL-1) ? 0 : y+1. row = ny - py, computed 11-bit signed. Row is in range when 0 ≤ row < SIZE. SIZE=16, or 32 with the optional feature.
- FSM states and transitions:
  - IDLE: on x==FETCH_X go to ADDR.
  - ADDR: line<=row[3:0] (scaled: row[4:1]); row_hit<=in-range && pen; go to DATA.
  - DATA: line_buf<=row_hit ? bits : 0; go to IDLE.
  - DRAW is tracked by an independent counter, so fetch and draw never conflict.
- Draw counter:
  - Start: when de && x==px && line_buf has been loaded for this line, cnt<=0 and drawing=1.
  - Advance: increments each cycle while drawing.
  - Stop: drawing ends after SIZE pixels or when de falls, whichever comes first. This clips at the right edge.
  - If px ≥ H_ACTIVE, the sprite is never drawn.
- Pixel select: nib = line_buf[63-4*k -: 4], with k=cnt (scaled: cnt>>1).
- Output, registered with 1-cycle latency:
  - rgb_out = !de ? 0 : (drawing && nib[0]) ? nib[3:1] : bg_rgb.
  - hit = de && drawing && nib[0].
  - de_out <= de.
- Transparent pixels (A=0) pass bg_rgb.
- Boundaries:
  - Sprite rows above line 0 are negative and never drawn; no vertical wrap.
  - py=V_TOTAL-1: row 0 is fetched when y=V_TOTAL-2; lines after the wrap are not drawn.
  - frame_start coincident with x==FETCH_X: the fetch uses the newly latched values.
  - reset_n low mid-line clears the output to 0 immediately; normal operation resumes from the next FETCH_X.

Optional Feature:
- Macro: SPRITE_SCALE2X_EN.
- Defined: sprite is drawn 32x32. Each ROM row covers 2 lines (line=row>>1) and each nibble is held 2 pixels.
- Undefined: 16x16, 1:1. Counter width and logic shrink accordingly.

Decomposition:
- Shared package vga_pkg: H_ACTIVE/V_TOTAL defaults, SPR_W=16, SPR_H=16, BPP=4, RGBA field offsets (R=3, G=2, B=1, A=0), and a 3-bit rgb typedef.
- One natural sub-module: sprite_line_buf. It holds the 64-bit row register and load logic and provides the nibble select by index. The FSM and compositor stay at top level.

Test Plan:
- Basic row: pos (100,50), bits row0=64'hF000_0000_0000_0001, bg=3'b010. On line 50: x=100 -> rgb_out 3'b111, hit=1, next cycle; x=101..114 -> 3'b010; x=115 -> 3'b000, hit=1; x=99 and x=116 -> bg.
- Fetch timing: y=49, x=FETCH_X -> line=0 the next cycle; x=FETCH_X+1 -> line_buf captured.
- Off-sprite line: y=70 -> line_buf=0, every pixel equals bg, hit never 1.
- Right clip: px=630 -> 10 sprite pixels drawn. de_out low from x=640 with rgb_out=0. No spill onto the next line at x=0.
- Position latch: change spr_x mid-frame to 200 -> the draw stays at 100 until after frame_start, then moves to 200. spr_en=0 latched -> no hits for the whole frame.
- Reset mid-draw: assert reset_n=0 at x=105 -> rgb_out, hit and de_out are 0 asynchronously. Release -> correct output from the next line's fetch. With SPRITE_SCALE2X_EN: lines 50/51 both use ROM row 0, and each pixel is doubled.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA/sprite constants, RGBA nibble layout, pixel type and fetch FSM states.
// Nibble layout is R,G,B,A with A in bit 0, so an opaque pixel's colour is nib[3:1].
package vga_pkg;
  localparam int H_ACTIVE = 640;
  localparam int H_TOTAL  = 800;
  localparam int V_TOTAL  = 525;
  localparam int SPR_W    = 16;
  localparam int SPR_H    = 16;
  localparam int BPP      = 4;
  localparam int R_OFS    = 3;
  localparam int G_OFS    = 2;
  localparam int B_OFS    = 1;
  localparam int A_OFS    = 0;

  typedef logic [2:0] rgb_t;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} fetch_st_e;

  function automatic logic [9:0] next_line(input logic [9:0] y, input int v_total);
    return (int'(y) == v_total - 1) ? 10'd0 : y + 10'd1;
  endfunction
endpackage

// File: rtl/sprite_renderer_if.sv
// Pixel stream, sprite control and sprite ROM signals between the VGA pipeline (master) and the renderer (slave).
// No handshake: everything moves at one pixel per clock.
interface sprite_renderer_if;
  import vga_pkg::*;

  logic        frame_start;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        de;
  logic        spr_en;
  logic [9:0]  spr_x;
  logic [9:0]  spr_y;
  rgb_t        bg_rgb;
  logic [3:0]  line;
  logic [63:0] bits;
  rgb_t        rgb_out;
  logic        de_out;
  logic        hit;

  modport master (
    output frame_start, x, y, de, spr_en, spr_x, spr_y, bg_rgb, bits,
    input  line, rgb_out, de_out, hit
  );

  modport slave (
    input  frame_start, x, y, de, spr_en, spr_x, spr_y, bg_rgb, bits,
    output line, rgb_out, de_out, hit
  );
endinterface

// File: rtl/sprite_line_buf.sv
// Holds one fetched sprite row and returns the RGBA nibble at a pixel index; vld_o marks a row loaded since reset.
// Load takes effect on the next clock; nibble select is combinational; no backpressure.
module sprite_line_buf
  import vga_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 ld_i,
  input  logic [SPR_W*BPP-1:0] row_i,
  input  logic [3:0]           idx_i,
  output logic [BPP-1:0]       nib_o,
  output logic                 vld_o
);
  localparam int ROW_W = SPR_W * BPP;

  logic [ROW_W-1:0] buf_q;
  logic [ROW_W-1:0] shifted;
  logic             vld_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_q <= '0;
      vld_q <= 1'b0;
    end else if (ld_i) begin
      buf_q <= row_i;
      vld_q <= 1'b1;
    end
  end

  // Pixel 0 sits in the top nibble, so shift the selected pixel up to it.
  assign shifted = buf_q << {idx_i, 2'b00};
  assign nib_o   = shifted[ROW_W-1 -: BPP];
  assign vld_o   = vld_q;
endmodule

// File: rtl/sprite_renderer.sv
// Composites one 16x16 RGBA sprite (32x32 under SPRITE_SCALE2X_EN) over the background stream, fetching rows in h-blank.
// Latency 1 cycle from x/y/de/bg_rgb to rgb_out/hit/de_out; no backpressure, one pixel per clock.
module sprite_renderer #(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int V_TOTAL  = vga_pkg::V_TOTAL,
  parameter int FETCH_X  = 640
) (
  input logic              clk,
  input logic              reset_n,
  sprite_renderer_if.slave bus
);
  import vga_pkg::*;

`ifdef SPRITE_SCALE2X_EN
  localparam int SC_SH = 1;
`else
  localparam int SC_SH = 0;
`endif
  localparam int H_SIZE = SPR_W << SC_SH;
  localparam int V_SIZE = SPR_H << SC_SH;
  localparam int CW     = $clog2(H_SIZE);

  fetch_st_e         state_q;
  logic [3:0]        line_q;
  logic              row_hit_q;
  logic [9:0]        px_q, py_q;
  logic              pen_q;
  logic [9:0]        ny;
  logic signed [10:0] row;
  logic              in_range;

  always_comb begin
    ny       = next_line(bus.y, V_TOTAL);
    row      = $signed({1'b0, ny}) - $signed({1'b0, py_q});
    in_range = !row[10] && (row[9:0] < 10'(V_SIZE));
  end

  // Row fetch for the next line; position is latched in the same block so a
  // frame_start on the FETCH_X cycle is already visible in ADDR.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      line_q    <= '0;
      row_hit_q <= 1'b0;
      px_q      <= '0;
      py_q      <= '0;
      pen_q     <= 1'b0;
    end else begin
      if (bus.frame_start) begin
        px_q  <= bus.spr_x;
        py_q  <= bus.spr_y;
        pen_q <= bus.spr_en;
      end
      case (state_q)
        IDLE: if (bus.x == 10'(FETCH_X)) state_q <= ADDR;
        ADDR: begin
          line_q    <= row[SC_SH +: 4];
          row_hit_q <= in_range && pen_q;
          state_q   <= DATA;
        end
        DATA:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.line = line_q;

  logic [63:0] row_dat;
  logic [3:0]  nib;
  logic [3:0]  nib_idx;
  logic        buf_vld;

  assign row_dat = row_hit_q ? bus.bits : '0;

  sprite_line_buf u_line_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .ld_i    (state_q == DATA),
    .row_i   (row_dat),
    .idx_i   (nib_idx),
    .nib_o   (nib),
    .vld_o   (buf_vld)
  );

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] idx;
  logic          drawing_q;
  logic          start;
  logic          active;

  // Pixel 0 must be shown on the x==px cycle itself, so the start cycle uses
  // index 0 directly and cnt_q holds the index for the following cycle.
  always_comb begin
    start  = bus.de && (bus.x == px_q) && (px_q < 10'(H_ACTIVE)) && buf_vld;
    active = start || (drawing_q && bus.de);
    idx    = start ? '0 : cnt_q;
  end

  assign nib_idx = idx[CW-1 -: 4];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      drawing_q <= 1'b0;
    end else if (start) begin
      cnt_q     <= CW'(1);
      drawing_q <= 1'b1;
    end else if (drawing_q && bus.de && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CW'(1);
    end else begin
      drawing_q <= 1'b0;
    end
  end

  rgb_t rgb_d, rgb_q;
  logic hit_d, hit_q, de_q;
  logic opaque;

  always_comb begin
    opaque = active && nib[A_OFS];
    rgb_d  = '0;
    if (bus.de) rgb_d = opaque ? nib[R_OFS -: 3] : bus.bg_rgb;
    hit_d  = bus.de && opaque;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rgb_q <= '0;
      hit_q <= 1'b0;
      de_q  <= 1'b0;
    end else begin
      rgb_q <= rgb_d;
      hit_q <= hit_d;
      de_q  <= bus.de;
    end
  end

  assign bus.rgb_out = rgb_q;
  assign bus.hit     = hit_q;
  assign bus.de_out  = de_q;
endmodule

// File: tb/tb_sprite_renderer.sv
// Randomized bench for sprite_renderer: stimulus pushes per-pixel expectations from a line-level model, a monitor compares.
// Lines are shortened to 650 pixels (640 active + blank covering the row fetch) to keep runs short.
module tb_sprite_renderer;
  import vga_pkg::*;

  localparam int FETCH_X = 640;
  localparam int H_LEN   = 650;
`ifdef SPRITE_SCALE2X_EN
  localparam int SC = 2;
`else
  localparam int SC = 1;
`endif
  localparam int SIZE = SPR_W * SC;
  localparam int SH   = SC - 1;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;

  sprite_renderer_if bus ();
  logic [63:0] rom [16];
  assign bus.bits = rom[bus.line];

  sprite_renderer #(.H_ACTIVE(640), .V_TOTAL(525), .FETCH_X(FETCH_X)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] rgb;
    logic       hit;
    logic       de;
    logic       chk_line;
    logic [3:0] line;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int vectors     = 0;
  int miscompares = 0;

  // Model state: latched sprite, row buffer for the next line, expected ROM index.
  int          m_px, m_py;
  bit          m_pen;
  logic [63:0] m_buf;
  bit          m_loaded;
  int          m_line;
  int          bg_fix = -1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_px = 0; m_py = 0; m_pen = 0; m_buf = '0; m_loaded = 0; m_line = 0;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        chk("pixel{rgb,hit,de}", 64'({bus.rgb_out, bus.hit, bus.de_out}),
            64'({mon_e.rgb, mon_e.hit, mon_e.de}));
        if (mon_e.chk_line) chk("rom_line", 64'(bus.line), 64'(mon_e.line));
      end
    end
  end

  task automatic cyc(input int xx, input int yy, input bit fs);
    exp_t        e;
    int          i, row, bg;
    logic [3:0]  nb;
    @(negedge clk);
    bg = (bg_fix < 0) ? int'($urandom_range(0, 7)) : bg_fix;
    bus.x           = 10'(xx);
    bus.y           = 10'(yy);
    bus.de          = (xx < 640);
    bus.frame_start = fs;
    bus.bg_rgb      = 3'(bg);
    e.rgb = '0; e.hit = 1'b0; e.de = (xx < 640); e.chk_line = 1'b0; e.line = '0;
    if (xx < 640) begin
      e.rgb = 3'(bg);
      i = xx - m_px;
      if (m_loaded && i >= 0 && i < SIZE) begin
        nb = m_buf[63 - 4*(i/SC) -: 4];
        if (nb[0]) begin
          e.rgb = nb[3:1];
          e.hit = 1'b1;
        end
      end
    end
    if (xx == FETCH_X + 1) begin
      row      = ((yy == V_TOTAL - 1) ? 0 : yy + 1) - m_py;
      m_buf    = (m_pen && row >= 0 && row < SIZE) ? rom[row / SC] : 64'd0;
      m_line   = (row >>> SH) & 15;
      m_loaded = 1;
      e.chk_line = 1'b1;
      e.line     = 4'(m_line);
    end
    if (fs) begin
      m_px  = int'(bus.spr_x);
      m_py  = int'(bus.spr_y);
      m_pen = bus.spr_en;
    end
    sb.push_back(e);
  endtask

  task automatic run_line(input int yy, input int fs_at);
    for (int xx = 0; xx < H_LEN; xx++) cyc(xx, yy, xx == fs_at);
  endtask

  task automatic set_spr(input int sx, input int sy, input bit en);
    bus.spr_x  = 10'(sx);
    bus.spr_y  = 10'(sy);
    bus.spr_en = en;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int y0, fs_at;
    bus.frame_start = 1'b0;
    bus.x = '0; bus.y = '0; bus.de = 1'b0; bus.bg_rgb = '0;
    set_spr(0, 0, 1'b0);
    rom[0] = 64'hF000_0000_0000_0001;
    for (int r = 1; r < 16; r++) rom[r] = {$urandom(), $urandom()};
    model_reset();

    #1 reset_n = 1'b0;
    #1;
    chk("reset rgb_out", 64'(bus.rgb_out), 64'd0);
    chk("reset hit",     64'(bus.hit),     64'd0);
    chk("reset de_out",  64'(bus.de_out),  64'd0);
    chk("reset line",    64'(bus.line),    64'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Basic row at (100,50) over a fixed background.
    bg_fix = 2;
    set_spr(100, 50, 1'b1);
    run_line(480, 645);
    for (int yy = 48; yy <= 52; yy++) run_line(yy, -1);
    for (int yy = 69; yy <= 71; yy++) run_line(yy, -1);
    bg_fix = -1;

    // Mid-frame position change only takes effect after frame_start.
    set_spr(200, 50, 1'b1);
    run_line(49, -1);
    run_line(50, -1);
    run_line(480, 645);
    run_line(49, -1);
    run_line(50, -1);

    // Right clip, with frame_start coincident with the fetch cycle.
    set_spr(630, 60, 1'b1);
    run_line(59, FETCH_X);
    run_line(60, -1);
    run_line(61, -1);

    // Disabled sprite for a whole frame.
    set_spr(100, 50, 1'b0);
    run_line(480, 645);
    for (int yy = 49; yy <= 51; yy++) run_line(yy, -1);

    // Sprite top on the last line: drawn there, nothing after the wrap.
    set_spr(300, 524, 1'b1);
    run_line(480, 645);
    run_line(522, -1);
    run_line(523, -1);
    run_line(524, -1);
    run_line(0, -1);

    for (int n = 0; n < 10; n++) begin
      for (int r = 0; r < 16; r++) rom[r] = {$urandom(), $urandom()};
      set_spr(int'($urandom_range(0, 700)), int'($urandom_range(0, 524)),
              $urandom_range(0, 3) != 0);
      fs_at = ($urandom_range(0, 1) == 1) ? FETCH_X : 645;
      y0 = (int'(bus.spr_y) + V_TOTAL - 1) % V_TOTAL;
      run_line(y0, fs_at);
      for (int k = 1; k <= 3; k++) run_line((y0 + k) % V_TOTAL, -1);
    end

    // Reset in the middle of a drawn sprite row.
    rom[0] = 64'hF000_0000_0000_0001;
    set_spr(100, 50, 1'b1);
    run_line(480, 645);
    run_line(49, -1);
    for (int xx = 0; xx <= 105; xx++) cyc(xx, 50, 1'b0);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midreset rgb_out", 64'(bus.rgb_out), 64'd0);
    chk("midreset hit",     64'(bus.hit),     64'd0);
    chk("midreset de_out",  64'(bus.de_out),  64'd0);
    chk("midreset line",    64'(bus.line),    64'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    bus.de = 1'b0;
    bus.x  = '0;
    reset_n = 1'b1;
    run_line(50, -1);
    run_line(480, 645);
    run_line(49, -1);
    run_line(50, -1);

    @(posedge clk);
    #2;
    chk("scoreboard drain", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
